// File: rtl/miner_sweep_ctrl.sv
// Nonce-sweep controller for the SHA-256d datapath. It issues interleaved nonce groups to NUM_CORES cores,
// checks each core hash LATENCY cycles later and queues winning nonces. Optional: MINER_SWEEP_CTRL_STATS_EN.
module miner_sweep_ctrl #(
  parameter int LOOP_LOG2  = 0,
  parameter int NUM_CORES  = 2,
  parameter int DIFFICULTY = 4,
  parameter int LATENCY    = 130,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      hash_clk,
  input  logic                      rst,
  // job_* and gold_* are valid/ready pairs: a transfer happens on a hash_clk edge where both are high;
  // gold_nonce holds steady while gold_valid && !gold_ready.
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [255:0]              job_midstate,
  input  logic [95:0]               job_tail,
  input  logic [31:0]               job_nonce_start,
  input  logic [31:0]               job_nonce_end,
  output logic [255:0]              core_state,
  output logic [95:0]               core_tail,
  output logic [32*NUM_CORES-1:0]   core_nonce,
  output logic [5:0]                core_cnt,
  output logic                      core_feedback,
  input  logic [256*NUM_CORES-1:0]  core_hash,
  output logic                      gold_valid,
  input  logic                      gold_ready,
  output logic [31:0]               gold_nonce,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                drop_count,
`ifdef MINER_SWEEP_CTRL_STATS_EN
  output logic [47:0]               stat_hashes,
`endif
  output logic [1:0]                state_dbg
);

  localparam int          LOOP     = 1 << LOOP_LOG2;
  localparam int          LANE_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int          WAIT_W   = $clog2(LATENCY + 1);
  localparam int          ADDR_W   = $clog2(FIFO_DEPTH);
  localparam logic [5:0]  CNT_MASK = 6'(LOOP - 1);
  localparam logic [31:0] STRIDE   = 32'(NUM_CORES);
  localparam logic [32:0] LAST_ADD = 33'(NUM_CORES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;
  state_t state_q, state_d;

  logic [31:0]          start_q, span_q, chk_base_q, pend_base_q;
  logic [31:0]          nonce_q [NUM_CORES];
  logic [WAIT_W-1:0]    wait_q;
  logic                 chk_done_q;
  logic [NUM_CORES-1:0] pend_q, hits, lane_ok, low_bit;
  logic [LANE_W-1:0]    low_idx;
  logic [3:0]           hit_cnt;
  logic [31:0]          fifo_mem [FIFO_DEPTH];
  logic [ADDR_W:0]      wr_ptr_q, rd_ptr_q;
  logic                 accept, issue, issue_last, check, chk_last;
  logic                 pend_empty, load_pend, drop_new;
  logic                 fifo_full, pop, push_req, push, push_drop;
  logic [31:0]          issue_off, chk_off;
  logic [4:0]           drop_inc;
  logic [8:0]           drop_sum;
  logic [7:0]           drop_d;
  logic                 unused_hash;

  // Offsets are taken relative to start so that a sweep across the 2^32 wrap needs no special case.
  always_comb begin
    accept     = (state_q == S_IDLE) && job_valid;
    issue      = (state_q == S_RUN) && (core_cnt == 6'd0);
    issue_off  = nonce_q[0] - start_q;
    issue_last = ({1'b0, issue_off} + LAST_ADD) >= {1'b0, span_q};
    check      = (state_q != S_IDLE) && (wait_q == '0) && (core_cnt == 6'd0) && !chk_done_q;
    chk_off    = chk_base_q - start_q;
    chk_last   = ({1'b0, chk_off} + LAST_ADD) >= {1'b0, span_q};
  end

  always_comb begin
    lane_ok = '0;
    hits    = '0;
    hit_cnt = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      lane_ok[k] = (chk_off + 32'(k)) <= span_q;
      hits[k]    = check && lane_ok[k] && (core_hash[256*k+255 -: DIFFICULTY] == '0);
      hit_cnt    = hit_cnt + 4'(hits[k]);
    end
  end

  always_comb begin
    low_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (pend_q[k]) low_idx = LANE_W'(k);
    end
    low_bit    = pend_q & (~pend_q + NUM_CORES'(1));
    pend_empty = (pend_q == '0);
    load_pend  = (hits != '0) && pend_empty;
    drop_new   = (hits != '0) && !pend_empty;
    fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    pop        = gold_valid && gold_ready;
    push_req   = !pend_empty;
    push       = push_req && (!fifo_full || pop);
    push_drop  = push_req && !push;
    drop_inc   = (drop_new ? {1'b0, hit_cnt} : 5'd0) + {4'd0, push_drop};
    drop_sum   = {1'b0, drop_count} + {4'd0, drop_inc};
    drop_d     = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (job_valid) state_d = S_RUN;
      S_RUN:   if (issue && issue_last) state_d = S_DRAIN;
      S_DRAIN: if (chk_done_q && pend_empty) begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign job_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign core_feedback = !issue;
  assign state_dbg     = state_q;
  assign gold_valid    = (wr_ptr_q != rd_ptr_q);
  assign gold_nonce    = fifo_mem[rd_ptr_q[ADDR_W-1:0]];
  assign unused_hash   = ^core_hash;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_lane
    assign core_nonce[32*g +: 32] = nonce_q[g];
  end

  always_ff @(posedge hash_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge hash_clk) begin
    if (rst) begin
      start_q     <= '0;
      span_q      <= '0;
      chk_base_q  <= '0;
      pend_base_q <= '0;
      wait_q      <= '0;
      chk_done_q  <= 1'b0;
      pend_q      <= '0;
      core_cnt    <= '0;
      core_state  <= '0;
      core_tail   <= '0;
      drop_count  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int k = 0; k < NUM_CORES; k++) nonce_q[k] <= '0;
    end else begin
      if (accept) begin
        start_q    <= job_nonce_start;
        span_q     <= job_nonce_end - job_nonce_start;
        chk_base_q <= job_nonce_start;
        wait_q     <= WAIT_W'(LATENCY);
        chk_done_q <= 1'b0;
        core_cnt   <= '0;
        core_state <= job_midstate;
        core_tail  <= job_tail;
        drop_count <= '0;
        for (int k = 0; k < NUM_CORES; k++) nonce_q[k] <= job_nonce_start + 32'(k);
      end else begin
        // Counter runs on after the last issue so the last group still gets its LOOP rounds.
        if ((state_q != S_IDLE) || (core_cnt != 6'd0)) core_cnt <= (core_cnt + 6'd1) & CNT_MASK;
        if ((state_q != S_IDLE) && (wait_q != '0)) wait_q <= wait_q - 1'b1;
        if (issue && !issue_last) begin
          for (int k = 0; k < NUM_CORES; k++) nonce_q[k] <= nonce_q[k] + STRIDE;
        end
        if (check) begin
          chk_base_q <= chk_base_q + STRIDE;
          if (chk_last) chk_done_q <= 1'b1;
        end
        drop_count <= drop_d;
      end
      if (load_pend) begin
        pend_q      <= hits;
        pend_base_q <= chk_base_q;
      end else if (!pend_empty) begin
        pend_q <= pend_q & ~low_bit;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (push) fifo_mem[wr_ptr_q[ADDR_W-1:0]] <= pend_base_q + 32'(low_idx);
  end

`ifdef MINER_SWEEP_CTRL_STATS_EN
  logic [3:0]  lane_cnt;
  logic [48:0] stat_sum;

  always_comb begin
    lane_cnt = '0;
    for (int k = 0; k < NUM_CORES; k++) lane_cnt = lane_cnt + 4'(lane_ok[k]);
    stat_sum = {1'b0, stat_hashes} + 49'(lane_cnt);
  end

  always_ff @(posedge hash_clk) begin
    if (rst)         stat_hashes <= '0;
    else if (accept) stat_hashes <= '0;
    else if (check)  stat_hashes <= stat_sum[48] ? '1 : stat_sum[47:0];
  end
`endif

endmodule

// File: tb/tb_miner_sweep_ctrl.sv
// Directed bench for miner_sweep_ctrl: a modelled core pipeline returns chosen winning hashes,
// and gold nonces, done timing, masking, wrap, drops and reset abort are compared to hand values.
module tb_miner_sweep_ctrl;
  localparam int LOOP_LOG2  = 0;
  localparam int NUM_CORES  = 2;
  localparam int DIFFICULTY = 4;
  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 2;
  localparam logic [255:0] MIDSTATE = {8{32'hA5C3_0F1E}};
  localparam logic [95:0]  TAIL     = 96'h0123_4567_89AB_CDEF_1357_9BDF;

  logic         hash_clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [255:0] job_midstate = MIDSTATE;
  logic [95:0]  job_tail = TAIL;
  logic [31:0]  job_nonce_start = '0;
  logic [31:0]  job_nonce_end = '0;
  logic [255:0] core_state;
  logic [95:0]  core_tail;
  logic [63:0]  core_nonce;
  logic [5:0]   core_cnt;
  logic         core_feedback;
  logic [511:0] core_hash;
  logic         gold_valid;
  logic         gold_ready = 1'b0;
  logic [31:0]  gold_nonce;
  logic         busy, done;
  logic [7:0]   drop_count;
  logic [1:0]   state_dbg;
`ifdef MINER_SWEEP_CTRL_STATS_EN
  logic [47:0]  stat_hashes;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int dc;

  miner_sweep_ctrl #(
    .LOOP_LOG2(LOOP_LOG2), .NUM_CORES(NUM_CORES), .DIFFICULTY(DIFFICULTY),
    .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .hash_clk(hash_clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_tail(job_tail),
    .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
    .core_state(core_state), .core_tail(core_tail), .core_nonce(core_nonce),
    .core_cnt(core_cnt), .core_feedback(core_feedback), .core_hash(core_hash),
    .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_nonce(gold_nonce),
    .busy(busy), .done(done), .drop_count(drop_count),
`ifdef MINER_SWEEP_CTRL_STATS_EN
    .stat_hashes(stat_hashes),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 hash_clk = ~hash_clk;

  // core model: nonce seen on the issue lane returns LATENCY cycles later as a hash
  logic [31:0] pipe0 [LATENCY];
  logic [31:0] pipe1 [LATENCY];
  logic [31:0] h0 = '0, h1 = '0, h2 = '0;
  logic [2:0]  hit_en = '0;

  always @(posedge hash_clk) begin
    pipe0[0] <= core_nonce[31:0];
    pipe1[0] <= core_nonce[63:32];
    for (int i = 1; i < LATENCY; i++) begin
      pipe0[i] <= pipe0[i-1];
      pipe1[i] <= pipe1[i-1];
    end
  end

  function automatic logic [255:0] model_hash(input logic [31:0] n, input logic [2:0] en,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c);
    if ((en[0] && n == a) || (en[1] && n == b) || (en[2] && n == c))
      return {4'h0, {252{1'b1}}};
    return {4'h1, 252'h0};
  endfunction

  assign core_hash = {model_hash(pipe1[LATENCY-1], hit_en, h0, h1, h2),
                      model_hash(pipe0[LATENCY-1], hit_en, h0, h1, h2)};

  // issue log, sampled on the falling edge
  logic [31:0] iss0_q[$];
  logic [31:0] iss1_q[$];
  always @(negedge hash_clk) begin
    if (!rst && !core_feedback) begin
      iss0_q.push_back(core_nonce[31:0]);
      iss1_q.push_back(core_nonce[63:32]);
    end
  end

  // scoreboard
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_hits(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [2:0] en);
    h0 = a; h1 = b; h2 = c; hit_en = en;
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input int hold,
                         output int done_cyc);
    int k;
    iss0_q.delete();
    iss1_q.delete();
    @(negedge hash_clk);
    job_nonce_start = s;
    job_nonce_end   = e;
    job_valid       = 1'b1;
    @(posedge hash_clk);
    @(negedge hash_clk);
    k = 1;
    job_nonce_start = 32'h80;
    if (hold == 0) job_valid = 1'b0;
    while (!done && k < 200) begin
      @(negedge hash_clk);
      k++;
      if (k > hold) job_valid = 1'b0;
    end
    job_valid = 1'b0;
    done_cyc = done ? k : -1;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp);
    @(negedge hash_clk);
    check_eq({tag, "_valid"}, 64'(gold_valid), 64'd1);
    check_eq(tag, 64'(gold_nonce), 64'(exp));
    gold_ready = 1'b1;
    @(negedge hash_clk);
    gold_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge hash_clk);
    @(negedge hash_clk);
    rst = 1'b0;
    check_eq("rst_job_ready", 64'(job_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_gold_valid", 64'(gold_valid), 64'd0);
    check_eq("rst_drop", 64'(drop_count), 64'd0);
    check_eq("rst_cnt", 64'(core_cnt), 64'd0);
    check_eq("rst_feedback", 64'(core_feedback), 64'd1);
    check_eq("rst_nonce", core_nonce, 64'd0);

    // single winner, job_valid held high while busy must be ignored
    set_hits(32'h13, 32'h0, 32'h0, 3'b001);
    run_job(32'h10, 32'h17, 2, dc);
    check_eq("A_done_cyc", 64'(dc), 64'd9);
    check_eq("A_n_issue", 64'(iss0_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("A_issue_l0", 64'(iss0_q[i]), 64'(32'h10 + 2 * i));
      check_eq("A_issue_l1", 64'(iss1_q[i]), 64'(32'h11 + 2 * i));
    end
    check_eq("A_core_state", 64'(core_state[63:0]), MIDSTATE[63:0]);
    check_eq("A_core_tail", 64'(core_tail[63:0]), TAIL[63:0]);
    @(negedge hash_clk);
    check_eq("A_idle_ready", 64'(job_ready), 64'd1);
    check_eq("A_idle_busy", 64'(busy), 64'd0);
    check_eq("A_drop", 64'(drop_count), 64'd0);
    pop_expect("A_gold", 32'h13);
    check_eq("A_empty", 64'(gold_valid), 64'd0);

    // two winners in one group, popped lowest lane first
    set_hits(32'h14, 32'h15, 32'h0, 3'b011);
    run_job(32'h10, 32'h17, 0, dc);
    check_eq("B_done_cyc", 64'(dc), 64'd10);
    check_eq("B_drop", 64'(drop_count), 64'd0);
    pop_expect("B_gold0", 32'h14);
    pop_expect("B_gold1", 32'h15);
    check_eq("B_empty", 64'(gold_valid), 64'd0);

    // winner lies in a masked lane past the end of the range
    set_hits(32'h13, 32'h0, 32'h0, 3'b001);
    run_job(32'h10, 32'h12, 0, dc);
    check_eq("C_done_cyc", 64'(dc), 64'd7);
    check_eq("C_n_issue", 64'(iss0_q.size()), 64'd2);
    check_eq("C_issue0", 64'(iss0_q[0]), 64'h10);
    check_eq("C_issue1", 64'(iss0_q[1]), 64'h12);
    @(negedge hash_clk);
    check_eq("C_empty", 64'(gold_valid), 64'd0);
    check_eq("C_drop", 64'(drop_count), 64'd0);

    // sweep across the 2^32 wrap
    set_hits(32'h0, 32'h0, 32'h0, 3'b001);
    run_job(32'hFFFF_FFFE, 32'h0000_0001, 0, dc);
    check_eq("D_done_cyc", 64'(dc), 64'd8);
    check_eq("D_n_issue", 64'(iss0_q.size()), 64'd2);
    check_eq("D_issue0_l0", 64'(iss0_q[0]), 64'hFFFF_FFFE);
    check_eq("D_issue0_l1", 64'(iss1_q[0]), 64'hFFFF_FFFF);
    check_eq("D_issue1_l0", 64'(iss0_q[1]), 64'h0);
    check_eq("D_issue1_l1", 64'(iss1_q[1]), 64'h1);
    pop_expect("D_gold", 32'h0);
    check_eq("D_empty", 64'(gold_valid), 64'd0);

    // FIFO full with no consumer: third winner dropped
    set_hits(32'h10, 32'h14, 32'h18, 3'b111);
    run_job(32'h10, 32'h1F, 0, dc);
    check_eq("E_done_cyc", 64'(dc), 64'd13);
    @(negedge hash_clk);
    check_eq("E_gold_valid", 64'(gold_valid), 64'd1);
    check_eq("E_drop", 64'(drop_count), 64'd1);
    pop_expect("E_gold0", 32'h10);
    pop_expect("E_gold1", 32'h14);
    check_eq("E_empty", 64'(gold_valid), 64'd0);

    // next job clears drop_count
    set_hits(32'h0, 32'h0, 32'h0, 3'b000);
    run_job(32'h10, 32'h17, 0, dc);
    check_eq("F_done_cyc", 64'(dc), 64'd9);
    check_eq("F_drop", 64'(drop_count), 64'd0);
`ifdef MINER_SWEEP_CTRL_STATS_EN
    check_eq("F_stat_hashes", 64'(stat_hashes), 64'd8);
`endif
    @(negedge hash_clk);
    check_eq("F_empty", 64'(gold_valid), 64'd0);

    // reset in the middle of RUN aborts the job, its winner never appears
    set_hits(32'h10, 32'h0, 32'h0, 3'b001);
    job_nonce_start = 32'h10;
    job_nonce_end   = 32'h17;
    job_valid       = 1'b1;
    @(posedge hash_clk);
    @(negedge hash_clk);
    job_valid = 1'b0;
    check_eq("G_busy_run", 64'(busy), 64'd1);
    @(negedge hash_clk);
    @(negedge hash_clk);
    rst = 1'b1;
    @(posedge hash_clk);
    @(negedge hash_clk);
    rst = 1'b0;
    check_eq("G_busy", 64'(busy), 64'd0);
    check_eq("G_job_ready", 64'(job_ready), 64'd1);
    check_eq("G_gold_valid", 64'(gold_valid), 64'd0);
    check_eq("G_drop", 64'(drop_count), 64'd0);
    check_eq("G_feedback", 64'(core_feedback), 64'd1);
    check_eq("G_state", 64'(state_dbg), 64'd0);
    repeat (12) @(negedge hash_clk);
    check_eq("G_late_gold", 64'(gold_valid), 64'd0);
    check_eq("G_late_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/miner_sweep_ctrl.md
Name: miner_sweep_ctrl

Overview:
Parametrised control unit for the SHA-256d mining datapath. It accepts a work job (midstate, header tail, nonce range) and sweeps that range across NUM_CORES external double-SHA-256 cores, interleaving nonces, with LOOP-cycle iterative sequencing. It checks each core's final hash against DIFFICULTY and queues winning nonces in a FIFO with a ready/valid output. It replaces the fixed single-core, free-running, unbounded-nonce control logic at the miner top level.

Parameters:
LOOP_LOG2, 0, core unroll factor; LOOP = 1<<LOOP_LOG2; range 0..5
NUM_CORES, 2, parallel cores; power of two, 1..8
DIFFICULTY, 4, leading hash bits [255 -: DIFFICULTY] that must be zero; 1..256
LATENCY, 130, cycles from a nonce issue to its hash on core_hash; must be a multiple of LOOP
FIFO_DEPTH, 4, golden-nonce FIFO entries; power of two, >=2

Ports:
hash_clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
job_valid  in  1  job offer
job_ready  out  1  high only in IDLE
job_midstate  in  256  first-block state; held on core_state
job_tail  in  96  header tail preceding the nonce
job_nonce_start  in  32  first nonce
job_nonce_end  in  32  last nonce, inclusive, mod 2^32
core_state  out  256  registered midstate
core_tail  out  96  registered tail
core_nonce  out  32*NUM_CORES  lane k nonce = base+k
core_cnt  out  6  round-group counter
core_feedback  out  1  0 on issue cycles
core_hash  in  256*NUM_CORES  second-hash result per lane
gold_valid  out  1  FIFO non-empty
gold_ready  in  1  FIFO pop
gold_nonce  out  32  FIFO head
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end
drop_count  out  8  saturating count of lost hits; cleared on job accept

Behaviour:
- Reset: state=IDLE, job_ready=1, busy=0, done=0, gold_valid=0, drop_count=0, core_cnt=0, core_feedback=1, core_nonce=0, FIFO and pending mask empty. Reset mid-job aborts immediately. Nothing is reported from the aborted job.
- States: IDLE -> RUN on job_valid&&job_ready (cycle T). Job fields are registered at T. base=start.
- RUN: the first issue is at T+1 (core_feedback=0, core_cnt=0). core_cnt = (core_cnt+1)&(LOOP-1). core_feedback = (next cnt != 0). LOOP==1 issues every cycle. At each later issue, base += NUM_CORES (mod 2^32).
- Last group: the group where (base-start) mod 2^32 + NUM_CORES-1 >= (end-start) mod 2^32. After it is issued -> DRAIN.
- Lane mask: lane k is valid iff (base-start+k) mod 2^32 <= (end-start) mod 2^32. Masked lanes are never reported. end==start-1 sweeps all 2^32 nonces.
- Check: the group issued at cycle t is checked at t+LATENCY. hit[k] = lane valid && core_hash[k][255 -: DIFFICULTY]==0. The checked group's nonces are reconstructed arithmetically: base_chk = base - (LATENCY/LOOP)*NUM_CORES, tracked by a separate check-base register. No nonce delay line.
- Hits load a pending mask one cycle after the check. One entry is pushed per cycle, lowest lane first.
- If a new check yields hits while the pending mask is non-empty, the new hits are dropped.
- A push to a full FIFO is dropped.
- Each dropped hit adds 1 to drop_count, saturating at 255.
- DRAIN: lasts until the last group's check is complete and the pending mask is empty. Then done=1 for one cycle -> IDLE.
- FIFO: simultaneous push and pop when full is allowed (pop first, then push succeeds). gold_nonce is stable while gold_valid&&!gold_ready. The FIFO persists across jobs.
- job_valid while busy: ignored.

Optional Feature:
MINER_SWEEP_CTRL_STATS_EN
- When defined: adds output stat_hashes [47:0], the count of unmasked lanes checked. Cleared on job accept, saturating, registered.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset mid-RUN (LATENCY=4, NUM_CORES=2) -> next cycle: busy=0, job_ready=1, gold_valid=0, drop_count=0, core_feedback=1.
- start=0x10, end=0x17, LOOP_LOG2=0, bench model gives hash top nibble 0 only for nonce 0x13 -> one gold_nonce=0x00000013; done pulses 4+4 cycles after first issue plus pending drain.
- Same job, hits on 0x14 and 0x15 (same group) -> FIFO pops 0x14 then 0x15, drop_count=0.
- start=0x10, end=0x12, model hits 0x13 -> nothing reported; lane 1 of the last group is masked.
- start=0xFFFFFFFE, end=0x00000001 -> issued nonces FFFFFFFE, FFFFFFFF, 0, 1; a hit on 0 reports 0x00000000.
- FIFO_DEPTH=2, gold_ready=0, three hits in separate groups -> gold_valid=1, 2 entries retained, drop_count=1; with STATS_EN, stat_hashes=8 for an 8-nonce job.
